transpose_load_seq: RTL and testbench
=====================================

// Module: transpose_load_seq
// PURPOSE
//  Sequencer for one transpose_fifo bank feeding the systolic array.
//  - Accepts DEPTH matrix rows over a valid/ready stream and writes each row into the FIFO (WrEn/Arow/Ain).
//  - Then asserts the FIFO shift enable for STREAM_CYCLES cycles so the skewed data drains into the array.
//  - Pulses done when the pass is complete. One instance per operand bank (A and B).
// PARAMETERS
//  DEPTH          8             rows per matrix = FIFO count = array dimension
//  BITS           8             element width
//  STREAM_CYCLES  3*DEPTH-2     cycles of fifo_en per pass; must be >= 1
// PORTS
//  clk          in   1                 clock, all logic on posedge
//  rst_n        in   1                 synchronous active-low reset
//  start        in   1                 begin a pass; sampled only while busy==0
//  abort        in   1                 synchronous cancel of the current pass
//  row_valid    in   1                 row_data holds a valid row
//  row_ready    out  1                 sequencer accepts a row this cycle
//  row_data     in   BITS x DEPTH      one matrix row, element [0] = column 0
//  fifo_WrEn    out  1                 row write strobe to the FIFO
//  fifo_Arow    out  clog2(DEPTH)      target row index of the write
//  fifo_Ain     out  BITS x DEPTH      row data to the FIFO
//  fifo_en      out  1                 FIFO shift enable
//  busy         out  1                 a pass is in progress
//  done         out  1                 one-cycle pulse at the end of a pass
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): every output is 0, state IDLE, counters 0.
//  - FSM states:
//    - IDLE: start moves to LOAD, row_cnt=0.
//    - LOAD: row_ready=1. On each handshake (row_valid&&row_ready), row_cnt++.
//      The handshake on row DEPTH-1 moves to STREAM, str_cnt=0.
//    - STREAM: str_cnt++ every cycle. At STREAM_CYCLES-1, move to DONE.
//    - DONE: one cycle, then IDLE.
//  - Output registration: row_ready is a decode of the state register.
//    fifo_WrEn, fifo_Arow, fifo_Ain, fifo_en, busy and done are all flops.
//    Each asserts one cycle after the state/handshake that causes it.
//  - Write path: a handshake in cycle t gives fifo_WrEn=1 in t+1, with Arow = the row_cnt at handshake and Ain = row_data sampled at t.
//    fifo_Ain holds its last value when WrEn=0.
//  - fifo_WrEn and fifo_en are never high in the same cycle.
//    The last write lands in the first STREAM cycle; fifo_en starts the cycle after it.
//  - Reference timeline: start at cycle 0, row_valid held 1, S=STREAM_CYCLES.
//    - row_ready: cycles 1..DEPTH
//    - WrEn: cycles 2..DEPTH+1, Arow 0..DEPTH-1
//    - fifo_en: cycles DEPTH+2..DEPTH+1+S
//    - done: cycle DEPTH+2+S
//    - busy: cycles 1..DEPTH+2+S
//  - Backpressure: row_valid low in LOAD means no write and row_cnt holds.
//    Gaps stretch LOAD only; STREAM length is fixed at S.
//  - row_cnt never wraps. Exactly DEPTH writes happen per pass, Arow strictly increments 0..DEPTH-1.
//  - start while busy is ignored. start in the done cycle is ignored; the earliest restart is the cycle after done.
//  - abort (any non-IDLE state): go to IDLE at the next edge; the cycle after, all outputs are 0 and no done pulse.
//    FIFO contents are not cleared; the next pass overwrites all rows.
//  - abort and start in the same cycle: abort wins and the pass does not begin.
//  - Reset mid-pass behaves as abort and also zeros fifo_Ain/fifo_Arow.
//  - Widths: row_cnt is clog2(DEPTH)+1 bits. str_cnt is clog2(STREAM_CYCLES)+1 bits.
//    Counters compare with equality, no overflow.
// STRUCTURE
//  - systolic_pkg: the seq_state_e enum (IDLE, LOAD, STREAM, DONE), DEPTH/BITS defaults, and the function stream_len(depth) = 3*depth-2.
//  - Sub-module cycle_counter #(W): sync clear, enable, terminal-count compare.
//    Instantiated twice (row_cnt, str_cnt).
// TESTING
//  1. DEPTH=8, start@0, row_valid=1 with rows r_i = {8{i}}:
//     - WrEn cycles 2..9 with Arow 0..7 and Ain {8{i}}
//     - fifo_en cycles 10..31
//     - done only at 32
//     - busy 1..32
//  2. row_valid low for 3 cycles after row 3:
//     - no WrEn during the gap
//     - Arow continues at 4
//     - fifo_en still exactly 22 cycles
//     - done shifted by +3 (cycle 35)
//  3. start pulsed at cycles 5 and 20 during a pass, then at 32 (done cycle):
//     - all ignored
//     - start at 33 begins a new pass, row_ready=1 at 34
//  4. abort at cycle 15 (STREAM):
//     - fifo_en=0 and busy=0 from cycle 16
//     - no done
//     - a fresh start then replays the test-1 timeline
//  5. rst_n=0 at cycle 6 (LOAD):
//     - all outputs 0 at cycle 7
//     - start@0 and abort@0 together: busy stays 0
//  6. Assertions throughout:
//     - never (fifo_WrEn && fifo_en)
//     - done is one cycle wide
//     - exactly DEPTH WrEn per completed pass

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic-array operand loaders.
// stream_len() gives the drain length needed for a skewed DEPTH x DEPTH tile.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  localparam int DEPTH_DEF = 8;
  localparam int BITS_DEF  = 8;

  function automatic int stream_len(input int depth);
    return 3 * depth - 2;
  endfunction

endpackage

// File: rtl/transpose_load_seq_cycle_counter.sv
// Up-counter with synchronous clear (dominant over enable) and a terminal-count flag.
// The flag is an equality compare, so the counter is never relied on to wrap.
module cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic         o_at_term
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_count   = r_cnt;
  assign o_at_term = (r_cnt == i_term);

endmodule

// File: rtl/transpose_load_seq.sv
// Loads DEPTH rows into one transpose_fifo bank, then drains it into the
// systolic array with STREAM_CYCLES cycles of shift enable and pulses done.
//
// Row stream handshake: a row transfers on a rising clk edge where
// row_valid && row_ready; row_ready depends only on the state register, and
// row_valid may rise or fall freely (there is no hold requirement).
module transpose_load_seq
  import systolic_pkg::*;
#(
  parameter int DEPTH         = DEPTH_DEF,
  parameter int BITS          = BITS_DEF,
  parameter int STREAM_CYCLES = stream_len(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic                                  row_valid,
  output logic                                  row_ready,
  input  logic [DEPTH*BITS-1:0]                 row_data,
  output logic                                  fifo_WrEn,
  output logic [$clog2(DEPTH)-1:0]              fifo_Arow,
  output logic [DEPTH*BITS-1:0]                 fifo_Ain,
  output logic                                  fifo_en,
  output logic                                  busy,
  output logic                                  done,
  output logic [1:0]                            dbg_state,
  output logic [$clog2(DEPTH):0]                dbg_row_cnt,
  output logic [$clog2(STREAM_CYCLES):0]        dbg_str_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = AW + 1;
  localparam int SW = $clog2(STREAM_CYCLES) + 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(DEPTH - 1);
  localparam logic [SW-1:0] STR_LAST = SW'(STREAM_CYCLES - 1);

  seq_state_e              r_state;
  logic                    r_wren;
  logic [AW-1:0]           r_arow;
  logic [DEPTH*BITS-1:0]   r_ain;
  logic                    r_en;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_ready;
  logic                    w_hs;
  logic                    w_go;
  logic                    w_to_stream;
  logic                    w_in_stream;
  logic [RW-1:0]           w_row_cnt;
  logic [SW-1:0]           w_str_cnt;
  logic                    w_row_last;
  logic                    w_str_last;

  // r_busy also covers the done cycle, which is why start is gated by it here.
  always_comb begin
    w_ready     = (r_state == LOAD);
    w_hs        = w_ready && row_valid;
    w_go        = (r_state == IDLE) && start && !r_busy && !abort;
    w_to_stream = w_hs && w_row_last;
    w_in_stream = (r_state == STREAM);
  end

  cycle_counter #(.W(RW)) u_row_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_go),
    .i_en      (w_hs),
    .i_term    (ROW_LAST),
    .o_count   (w_row_cnt),
    .o_at_term (w_row_last)
  );

  cycle_counter #(.W(SW)) u_str_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_to_stream),
    .i_en      (w_in_stream),
    .i_term    (STR_LAST),
    .o_count   (w_str_cnt),
    .o_at_term (w_str_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wren  <= 1'b0;
      r_arow  <= '0;
      r_ain   <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_wren <= w_hs && !abort;
      // Arow/Ain keep the last write so the FIFO sees stable data between strobes.
      if (w_hs && !abort) begin
        r_arow <= w_row_cnt[AW-1:0];
        r_ain  <= row_data;
      end
      r_en   <= w_in_stream && !abort;
      r_done <= (r_state == DONE) && !abort;
      if (abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_busy <= w_go;
            if (w_go) r_state <= LOAD;
          end
          LOAD: begin
            r_busy <= 1'b1;
            if (w_to_stream) r_state <= STREAM;
          end
          STREAM: begin
            r_busy <= 1'b1;
            if (w_str_last) r_state <= DONE;
          end
          DONE: begin
            r_busy  <= 1'b1;
            r_state <= IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign row_ready   = w_ready;
  assign fifo_WrEn   = r_wren;
  assign fifo_Arow   = r_arow;
  assign fifo_Ain    = r_ain;
  assign fifo_en     = r_en;
  assign busy        = r_busy;
  assign done        = r_done;
  assign dbg_state   = r_state;
  assign dbg_row_cnt = w_row_cnt;
  assign dbg_str_cnt = w_str_cnt;

endmodule

// File: tb/tb_transpose_load_seq.sv
// Bench for transpose_load_seq: expected outputs come from a pass timeline
// derived from handshake cycles, with a queue of rows awaiting their write strobe.
module tb_transpose_load_seq;

  localparam int DEPTH = 8;
  localparam int BITS  = 8;
  localparam int S     = 3 * DEPTH - 2;
  localparam int DW    = DEPTH * BITS;
  localparam int AW    = $clog2(DEPTH);
  localparam int MAXC  = 600;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic            row_valid;
  logic            row_ready;
  logic [DW-1:0]   row_data;
  logic            fifo_WrEn;
  logic [AW-1:0]   fifo_Arow;
  logic [DW-1:0]   fifo_Ain;
  logic            fifo_en;
  logic            busy;
  logic            done;
  logic [1:0]      dbg_state;
  logic [AW:0]     dbg_row_cnt;
  logic [$clog2(S):0] dbg_str_cnt;

  int checks;
  int errors;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_ain;
  logic [AW-1:0] exp_arow;

  transpose_load_seq #(.DEPTH(DEPTH), .BITS(BITS), .STREAM_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .row_data    (row_data),
    .fifo_WrEn   (fifo_WrEn),
    .fifo_Arow   (fifo_Arow),
    .fifo_Ain    (fifo_Ain),
    .fifo_en     (fifo_en),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state),
    .dbg_row_cnt (dbg_row_cnt),
    .dbg_str_cnt (dbg_str_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One pass: cycle t=0 carries start. Ends at the negedge of the done cycle
  // (or two cycles after an abort), so the next pass may start right after.
  task automatic run_pass(input int pct, input int gap_after, input int abort_at,
                          input bit noise, input bit inc_pattern);
    int hs, last_hs, gap_left, wr_idx, wr_seen, done_seen;
    bit wr_pending, fin, aborted;
    logic e_ready, e_en, e_done, e_busy;
    logic [7:0] b;
    hs = 0; last_hs = -1; gap_left = 3; wr_idx = 0; wr_seen = 0; done_seen = 0;
    wr_pending = 0; fin = 0;
    exp_q.delete();
    for (int t = 0; t < MAXC; t++) begin
      @(posedge clk); #1;
      start = (t == 0) || (noise && (t == 5 || t == 20 || (last_hs >= 0 && t == last_hs + 2 + S)));
      abort = (t == abort_at);
      if (gap_after >= 0 && hs == gap_after + 1 && gap_left > 0) begin
        row_valid = 1'b0;
        gap_left--;
      end else begin
        row_valid = ($urandom_range(0, 99) < pct);
      end
      if (inc_pattern) begin
        b = 8'(hs);
        row_data = {DEPTH{b}};
      end else begin
        row_data = {$urandom(), $urandom()};
      end
      @(negedge clk);
      aborted = (abort_at >= 0) && (t > abort_at);
      e_ready = !aborted && t >= 1 && hs < DEPTH;
      e_en    = !aborted && last_hs >= 0 && t >= last_hs + 2 && t <= last_hs + 1 + S;
      e_done  = !aborted && last_hs >= 0 && t == last_hs + 2 + S;
      e_busy  = !aborted && t >= 1 && (last_hs < 0 || t <= last_hs + 2 + S);
      if (wr_pending) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty t=%0d: write expected with no queued row", t);
        end else begin
          exp_ain = exp_q.pop_front();
        end
        exp_arow = AW'(wr_idx);
        wr_idx++;
      end
      checks++;
      if (row_ready !== e_ready) begin
        errors++; $display("FAIL row_ready t=%0d: got %b want %b", t, row_ready, e_ready);
      end
      checks++;
      if (fifo_WrEn !== wr_pending) begin
        errors++; $display("FAIL fifo_WrEn t=%0d: got %b want %b", t, fifo_WrEn, wr_pending);
      end
      checks++;
      if (fifo_en !== e_en) begin
        errors++; $display("FAIL fifo_en t=%0d: got %b want %b", t, fifo_en, e_en);
      end
      checks++;
      if (done !== e_done) begin
        errors++; $display("FAIL done t=%0d: got %b want %b", t, done, e_done);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++; $display("FAIL busy t=%0d: got %b want %b", t, busy, e_busy);
      end
      checks++;
      if (fifo_Ain !== exp_ain) begin
        errors++; $display("FAIL fifo_Ain t=%0d: got %h want %h", t, fifo_Ain, exp_ain);
      end
      checks++;
      if (fifo_Arow !== exp_arow) begin
        errors++; $display("FAIL fifo_Arow t=%0d: got %0d want %0d", t, fifo_Arow, exp_arow);
      end
      checks++;
      if (fifo_WrEn === 1'b1 && fifo_en === 1'b1) begin
        errors++; $display("FAIL wren_en_overlap t=%0d: got both 1 want exclusive", t);
      end
      if (fifo_WrEn === 1'b1) wr_seen++;
      if (done === 1'b1) done_seen++;
      wr_pending = e_ready && row_valid && (t != abort_at);
      if (e_ready && row_valid) begin
        if (t != abort_at) exp_q.push_back(row_data);
        hs++;
        if (hs == DEPTH) last_hs = t;
      end
      if ((abort_at < 0 && last_hs >= 0 && t == last_hs + 2 + S) ||
          (abort_at >= 0 && t == abort_at + 2)) begin
        fin = 1;
        break;
      end
    end
    start = 1'b0; abort = 1'b0; row_valid = 1'b0;
    checks++;
    if (!fin) begin
      errors++; $display("FAIL pass_timeout: got no pass end within %0d cycles want end", MAXC);
    end
    checks++;
    if (abort_at < 0 && wr_seen != DEPTH) begin
      errors++; $display("FAIL write_count: got %0d want %0d", wr_seen, DEPTH);
    end
    checks++;
    if (done_seen != ((abort_at < 0) ? 1 : 0)) begin
      errors++; $display("FAIL done_pulses: got %0d want %0d", done_seen, (abort_at < 0) ? 1 : 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({row_ready, fifo_WrEn, fifo_en, busy, done} !== 5'b0 || fifo_Arow !== '0 ||
        fifo_Ain !== '0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL %s: got ready=%b wren=%b en=%b busy=%b done=%b arow=%0d ain=%h st=%0d want all 0",
               tag, row_ready, fifo_WrEn, fifo_en, busy, done, fifo_Arow, fifo_Ain, dbg_state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; row_valid = 1'b0; row_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset_release");
    exp_ain = '0;
    exp_arow = '0;
  endtask

  task automatic test_basic();
    run_pass(100, -1, -1, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    run_pass(100, 3, -1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_pass(100, -1, -1, 1'b1, 1'b1);
    run_pass(100, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    run_pass(100, -1, 15, 1'b0, 1'b0);
    run_pass(100, -1, -1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    for (int t = 0; t <= 10; t++) begin
      @(posedge clk); #1;
      start = (t == 0) || (t == 8);
      abort = (t == 8);
      rst_n = (t != 6);
      row_valid = (t <= 6);
      b = 8'(t);
      row_data = {DEPTH{b}};
      @(negedge clk);
      if (t == 7) check_all_zero("reset_mid_pass");
      if (t >= 9) begin
        checks++;
        if (busy !== 1'b0 || row_ready !== 1'b0) begin
          errors++;
          $display("FAIL start_abort_together t=%0d: got busy=%b ready=%b want 0 0", t, busy, row_ready);
        end
      end
    end
    start = 1'b0; abort = 1'b0; row_valid = 1'b0;
    exp_ain = '0;
    exp_arow = '0;
  endtask

  task automatic test_random();
    for (int p = 0; p < 4; p++) begin
      run_pass($urandom_range(40, 90), -1, -1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
